// File: rtl/scalar_rf_dump.sv
// Scalar register-file drain engine.
// Walks registers 0..NREGS-1 through one read port and streams them out.
module scalar_rf_dump #(
  parameter int WIDTH = 16,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             finish,
  input  logic             start,
  output logic [4:0]       rs,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_index,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] LAST = 5'(NREGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [4:0] idx;
  logic       finish_q;
  logic       trig;
  logic       hs;
  logic       at_last;

  assign trig    = (finish & ~finish_q) | start;
  assign hs      = out_valid & out_ready;
  assign at_last = (idx == LAST);
  assign rs      = idx;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state and status outputs.
  always_comb begin
    state_n   = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig) state_n = READ;
      end
      READ: begin
        busy    = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = at_last ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Index walk, read capture and finish edge tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      finish_q  <= 1'b0;
      idx       <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      finish_q <= finish;
      unique case (state)
        IDLE: begin
          if (trig) idx <= '0;
        end
        READ: begin
          out_data  <= rd_data;
          out_index <= idx;
          out_last  <= at_last;
        end
        SEND: begin
          if (hs && !at_last) idx <= idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_rf_dump.sv
// Bench for scalar_rf_dump: scenario table, scoreboard queue,
// hand sequences for NREGS=1, reset mid-dump and reset-edge trigger.
module tb_scalar_rf_dump;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         finish = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b1;
  logic [4:0]   rs;
  logic [W-1:0] rd_data;
  logic         out_valid;
  logic [4:0]   out_index;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  logic         finish1 = 1'b0;
  logic         start1 = 1'b0;
  logic         ready1 = 1'b1;
  logic [4:0]   rs1;
  logic [W-1:0] rd1;
  logic         valid1;
  logic [4:0]   index1;
  logic [W-1:0] data1;
  logic         last1;
  logic         busy1;
  logic         done1;

  logic [W-1:0] rf [32];

  always #5 clk = ~clk;

  assign rd_data = rf[rs];
  assign rd1     = rf[rs1];

  scalar_rf_dump #(.WIDTH(W), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .finish(finish), .start(start),
    .rs(rs), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  scalar_rf_dump #(.WIDTH(W), .NREGS(1)) dut1 (
    .clk(clk), .rst(rst), .finish(finish1), .start(start1),
    .rs(rs1), .rd_data(rd1),
    .out_valid(valid1), .out_ready(ready1),
    .out_index(index1), .out_data(data1),
    .out_last(last1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [4:0]   idx;
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    string nm;
    int    kind;
    int    stall;
    bit    mid;
    int    lat;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   words = 0;
  int   dones = 0;
  int   read_start = -1;
  int   done_lat = -1;
  int   stall_idx = 1;
  int   stall_rem = 0;
  bit   held = 1'b0;
  logic [4:0]   h_idx;
  logic [W-1:0] h_data;
  logic         h_last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++)
      q.push_back('{5'(i), rf[i], (i == 31)});
  endtask

  task automatic clr();
    words      = 0;
    dones      = 0;
    read_start = -1;
    done_lat   = -1;
  endtask

  task automatic run_dump(input string nm, input int lat);
    int n;
    n = 0;
    while (dones == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({nm, "_words"}, words, 32);
    chk({nm, "_dones"}, dones, 1);
    chk({nm, "_lat"}, done_lat, lat);
    chk({nm, "_qleft"}, q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Backpressure driver: drop ready while the chosen index is offered.
  always @(posedge clk) begin
    #1;
    if (stall_rem > 0 && out_valid && out_index == 5'(stall_idx)) begin
      out_ready = 1'b0;
      stall_rem--;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: scoreboard pop, hold stability, done latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      held = 1'b0;
    end else begin
      if (busy && !out_valid && read_start < 0) read_start = cyc;
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_idx", out_index, h_idx);
        chk("hold_data", out_data, h_data);
        chk("hold_last", out_last, h_last);
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        words++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word actual=%0d required=none", out_index);
        end else begin
          e = q.pop_front();
          chk("word_idx", out_index, e.idx);
          chk("word_data", out_data, e.data);
          chk("word_last", out_last, e.last);
        end
      end else if (out_valid) begin
        held   = 1'b1;
        h_idx  = out_index;
        h_data = out_data;
        h_last = out_last;
      end
      if (done) begin
        dones++;
        done_lat = cyc - read_start;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    int   n;
    int   seen;
    vt[0] = '{"auto", 0, 0, 1'b0, 64};
    vt[1] = '{"bp", 1, 5, 1'b0, 69};
    vt[2] = '{"midstart", 1, 0, 1'b1, 64};
    vt[3] = '{"refinish", 2, 0, 1'b0, 64};

    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1]  = 19'd200000;
    rf[10] = 19'd199983;

    #1;
    chk("rst_rs", rs, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_index", out_index, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      clr();
      stall_idx = 1;
      stall_rem = vt[v].stall;
      if (vt[v].kind == 0) begin
        rf[28] = 19'd333;
        finish = 1'b1;
        push_dump();
      end else if (vt[v].kind == 1) begin
        start = 1'b1;
        push_dump();
        @(negedge clk);
        start = 1'b0;
      end else begin
        finish = 1'b0;
        @(negedge clk);
        finish = 1'b1;
        push_dump();
      end
      if (vt[v].mid) begin
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      run_dump(vt[v].nm, vt[v].lat);
    end

    clr();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("held_no_dump", seen + words, 0);

    rf[0] = 19'd12345;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_read_busy", busy1, 1);
    chk("n1_read_valid", valid1, 0);
    @(negedge clk);
    chk("n1_valid", valid1, 1);
    chk("n1_idx", index1, 0);
    chk("n1_data", data1, 12345);
    chk("n1_last", last1, 1);
    @(negedge clk);
    chk("n1_done", done1, 1);
    chk("n1_busy_off", busy1, 0);
    @(negedge clk);
    chk("n1_done_off", done1, 0);

    finish = 1'b0;
    repeat (2) @(negedge clk);
    clr();
    start = 1'b1;
    push_dump();
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_index == 5'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach7", out_index, 7);
    rst = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_rs", rs, 0);
    chk("mid_busy", busy, 0);
    chk("mid_index", out_index, 0);
    chk("mid_data", out_data, 0);
    q.delete();
    clr();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_no_done", dones + words, 0);
    clr();
    start = 1'b1;
    push_dump();
    @(negedge clk);
    start = 1'b0;
    run_dump("restart", 64);

    rst = 1'b0;
    finish = 1'b1;
    clr();
    repeat (2) @(negedge clk);
    push_dump();
    rst = 1'b1;
    @(negedge clk);
    chk("rstedge_read", busy && !out_valid, 1);
    run_dump("rstedge", 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
